// File: rtl/tpu_cfg_pkg.sv
// Shared address map, version constant and APB phase encoding for tpu_cfg_regfile.
package tpu_cfg_pkg;

  localparam int unsigned CtrlOffs    = 32'h00;
  localparam int unsigned StatusOffs  = 32'h04;
  localparam int unsigned IrqEnOffs   = 32'h08;
  localparam int unsigned VersionOffs = 32'h0C;
  localparam int unsigned GenBaseOffs = 32'h10;

  localparam logic [31:0] VersionVal = 32'h0001_0000;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

endpackage

// File: rtl/tpu_cfg_apb_fsm.sv
// APB phase tracker: one wait state, commit strobes at the end of SETUP, PREADY in ACCESS.
module tpu_cfg_apb_fsm
  import tpu_cfg_pkg::*;
(
  input  logic PCLK,
  input  logic PRESET,
  input  logic PSEL,
  input  logic PENABLE,
  input  logic PWRITE,
  output logic wr_en,
  output logic rd_en,
  output logic PREADY
);

  apb_state_e state_q;
  logic       ready_q;
  logic       commit;

  // The commit edge closes SETUP, so register effects and PRDATA are in place for ACCESS.
  assign commit = (state_q == StSetup) && PSEL && PENABLE;
  assign wr_en  = commit && PWRITE;
  assign rd_en  = commit && !PWRITE;
  assign PREADY = ready_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          state_q <= (PSEL && !PENABLE) ? StSetup : StIdle;
        end
        StSetup: begin
          if (commit) begin
            state_q <= StAccess;
            ready_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StAccess: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/tpu_cfg_regfile.sv
// APB configuration register file for the TPU core: control, status, irq and generic registers.
// Define CFG_PSTRB_EN to honour PSTRB byte lanes; otherwise every write is full-word.
module tpu_cfg_regfile
  import tpu_cfg_pkg::*;
#(
  parameter int unsigned                  ADDR_W   = 8,
  parameter int unsigned                  DATA_W   = 32,
  parameter int unsigned                  NUM_REGS = 16,
  parameter logic [NUM_REGS*DATA_W-1:0]   RST_VALS = '0
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [DATA_W-1:0]            PWDATA,
  input  logic [DATA_W/8-1:0]          PSTRB,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  input  logic                         done_tpu,
  input  logic                         busy_tpu,
  output logic                         start_tpu,
  output logic                         irq,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_regs
);

  localparam int unsigned StrbW = DATA_W / 8;

  logic              wr_en;
  logic              rd_en;
  logic [StrbW-1:0]  strb;
  logic [DATA_W-1:0] bmask;

  logic [31:0]       addr;
  logic [31:0]       gen_idx;
  logic              misaligned;
  logic              is_ctrl, is_status, is_irq_en, is_version, is_gen;
  logic              start_req, w1c_req, err, wr_ok;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              done_q, done_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q;
  logic              start_pend_q, start_q;
  logic [DATA_W-1:0] prdata_q;
  logic              pslverr_q;

  tpu_cfg_apb_fsm u_apb_fsm (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .PREADY  (PREADY)
  );

`ifdef CFG_PSTRB_EN
  assign strb = PSTRB;
`else
  logic unused_pstrb;
  assign strb         = '1;
  assign unused_pstrb = ^PSTRB;
`endif

  always_comb begin
    bmask = '0;
    for (int unsigned b = 0; b < StrbW; b++) begin
      bmask[b*8 +: 8] = {8{strb[b]}};
    end
  end

  // Address decode on a zero-extended byte address.
  assign addr       = 32'(PADDR);
  assign misaligned = |PADDR[1:0];
  assign is_ctrl    = (addr == CtrlOffs);
  assign is_status  = (addr == StatusOffs);
  assign is_irq_en  = (addr == IrqEnOffs);
  assign is_version = (addr == VersionOffs);
  assign gen_idx    = (addr - GenBaseOffs) >> 2;
  assign is_gen     = !misaligned && (addr >= GenBaseOffs) && (gen_idx < NUM_REGS);

  assign start_req = is_ctrl && PWDATA[0] && strb[0];
  assign w1c_req   = is_status && PWDATA[0] && strb[0];

  assign err = !(is_ctrl || is_status || is_irq_en || is_version || is_gen)
               || (PWRITE && is_version)
               || (PWRITE && start_req && busy_tpu);

  assign wr_ok = wr_en && !err;

  always_comb begin
    rd_data = '0;
    if (is_status) begin
      rd_data[1:0] = {busy_tpu, done_q};
    end else if (is_irq_en) begin
      rd_data[0] = irq_en_q;
    end else if (is_version) begin
      rd_data = DATA_W'(VersionVal);
    end else if (is_gen) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (gen_idx == i) rd_data = regs_q[i];
      end
    end
  end

  always_comb begin
    done_d   = done_q;
    irq_en_d = irq_en_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_ok) begin
      if (w1c_req) done_d = 1'b0;
      if (is_irq_en && strb[0]) irq_en_d = PWDATA[0];
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (is_gen && (gen_idx == i)) regs_d[i] = (regs_q[i] & ~bmask) | (PWDATA & bmask);
      end
    end
    // A completion landing with a clear must not be lost.
    if (done_tpu) done_d = 1'b1;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      done_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      start_pend_q <= 1'b0;
      start_q      <= 1'b0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RST_VALS[i*DATA_W +: DATA_W];
      end
    end else begin
      done_q       <= done_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= done_q & irq_en_q;
      // Start is accepted at the commit edge but presented the cycle after ACCESS.
      start_pend_q <= wr_ok && start_req;
      start_q      <= start_pend_q;
      prdata_q     <= (rd_en && !err) ? rd_data : '0;
      pslverr_q    <= (wr_en || rd_en) && err;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    cfg_regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cfg_regs[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign PRDATA    = prdata_q;
  assign PSLVERR   = pslverr_q;
  assign start_tpu = start_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_tpu_cfg_regfile.sv
// Randomised APB bench for tpu_cfg_regfile against an address-map level reference model.
module tb_tpu_cfg_regfile;

  localparam int unsigned NRegs = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = NRegs * DW;

  function automatic logic [CW-1:0] mk_rst();
    logic [CW-1:0] v;
    v        = '0;
    v[31:0]  = 32'h0000_00AA;
    for (int i = 1; i < NRegs; i++) v[i*DW +: DW] = 32'h5A00_0000 + 32'(i * 'h111);
    return v;
  endfunction

  localparam logic [CW-1:0] RstVals = mk_rst();

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [7:0]    PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [31:0]   PWDATA;
  logic [3:0]    PSTRB;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic          done_tpu, busy_tpu;
  logic          start_tpu, irq;
  logic [CW-1:0] cfg_regs;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [NRegs];
  logic        m_done;
  logic        m_irq_en;

  logic [31:0] last_rd;
  logic        last_err;
  logic        last_start;

  tpu_cfg_regfile #(
    .ADDR_W   (8),
    .DATA_W   (DW),
    .NUM_REGS (NRegs),
    .RST_VALS (RstVals)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .done_tpu  (done_tpu),
    .busy_tpu  (busy_tpu),
    .start_tpu (start_tpu),
    .irq       (irq),
    .cfg_regs  (cfg_regs)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] m_flat();
    logic [CW-1:0] v;
    for (int i = 0; i < NRegs; i++) v[i*DW +: DW] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NRegs; i++) m_regs[i] = RstVals[i*DW +: DW];
    m_done   = 1'b0;
    m_irq_en = 1'b0;
  endtask

  // Register-map semantics of one APB transfer.
  task automatic model_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, input logic busy, input logic hit_done,
                            output logic err, output logic [31:0] rd, output logic start);
    int          a;
    int          idx;
    logic [3:0]  s;
    a     = int'(addr);
    err   = 1'b0;
    rd    = 32'd0;
    start = 1'b0;
`ifdef CFG_PSTRB_EN
    s = strb;
`else
    s = 4'hF;
`endif
    if (a % 4 != 0) begin
      err = 1'b1;
    end else if (a >= 16) begin
      idx = (a - 16) / 4;
      if (idx >= NRegs) begin
        err = 1'b1;
      end else if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) m_regs[idx][b*8 +: 8] = wd[b*8 +: 8];
        end
      end else begin
        rd = m_regs[idx];
      end
    end else begin
      case (a)
        0: begin
          if (wr && wd[0] && s[0]) begin
            if (busy) err = 1'b1;
            else start = 1'b1;
          end
        end
        4: begin
          if (wr) begin
            if (wd[0] && s[0]) m_done = 1'b0;
          end else begin
            rd = {30'd0, busy, m_done};
          end
        end
        8: begin
          if (wr) begin
            if (s[0]) m_irq_en = wd[0];
          end else begin
            rd = {31'd0, m_irq_en};
          end
        end
        default: begin
          if (wr) err = 1'b1;
          else rd = 32'h0001_0000;
        end
      endcase
    end
    if (hit_done) m_done = 1'b1;
  endtask

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb, input logic hit_done,
                     output logic [31:0] rd, output logic err, output logic st_acc,
                     output logic st_after, output logic [CW-1:0] cfg_after,
                     output logic irq_after);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = strb;
    @(posedge PCLK); #1;
    check("prdata_setup", CW'(PRDATA), CW'(0));
    check("pready_setup", CW'(PREADY), CW'(0));
    PENABLE  = 1'b1;
    done_tpu = hit_done;
    @(posedge PCLK); #1;
    done_tpu = 1'b0;
    check("pready_access", CW'(PREADY), CW'(1));
    rd     = PRDATA;
    err    = PSLVERR;
    st_acc = start_tpu;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    st_after  = start_tpu;
    cfg_after = cfg_regs;
    irq_after = irq;
  endtask

  task automatic do_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic hit_done);
    logic [31:0]   rd, e_rd;
    logic          err, e_err, st_acc, st_after, e_start, irq_after;
    logic [CW-1:0] cfg_after;
    apb(wr, addr, wd, strb, hit_done, rd, err, st_acc, st_after, cfg_after, irq_after);
    model_xfer(wr, addr, wd, strb, busy_tpu, hit_done, e_err, e_rd, e_start);
    check("prdata", CW'(rd), CW'(e_rd));
    check("pslverr", CW'(err), CW'(e_err));
    check("start_in_access", CW'(st_acc), CW'(0));
    check("start_after_access", CW'(st_after), CW'(e_start));
    check("cfg_regs", cfg_after, m_flat());
    check("irq", CW'(irq_after), CW'(m_done & m_irq_en));
    @(posedge PCLK); #1;
    check("start_width", CW'(start_tpu), CW'(0));
    last_rd    = rd;
    last_err   = err;
    last_start = st_after;
  endtask

  task automatic pulse_done();
    @(posedge PCLK); #1;
    done_tpu = 1'b1;
    @(posedge PCLK); #1;
    done_tpu = 1'b0;
    m_done   = 1'b1;
    @(posedge PCLK); #1;
    check("irq_after_done", CW'(irq), CW'(m_done & m_irq_en));
  endtask

  task automatic check_reset_outputs();
    check("rst_prdata", CW'(PRDATA), CW'(0));
    check("rst_pready", CW'(PREADY), CW'(0));
    check("rst_pslverr", CW'(PSLVERR), CW'(0));
    check("rst_start", CW'(start_tpu), CW'(0));
    check("rst_irq", CW'(irq), CW'(0));
    check("rst_cfg_regs", cfg_regs, RstVals);
  endtask

  initial begin
    logic [7:0] a;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
    PWDATA = '0; PSTRB = 4'hF; done_tpu = 1'b0; busy_tpu = 1'b0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    check_reset_outputs();
    @(negedge PCLK);
    PRESET = 1'b0;

    // Reset image of register 0.
    do_xfer(1'b0, 8'h10, 32'h0, 4'hF, 1'b0);
    check("rst_reg0_literal", CW'(last_rd), CW'(32'h0000_00AA));

    do_xfer(1'b1, 8'h14, 32'hDEAD_BEEF, 4'hF, 1'b0);
    check("cfg_reg1_literal", CW'(cfg_regs[63:32]), CW'(32'hDEAD_BEEF));
    do_xfer(1'b0, 8'h14, 32'h0, 4'hF, 1'b0);
    check("reg1_literal", CW'(last_rd), CW'(32'hDEAD_BEEF));

    // DONE / irq, including a clear colliding with a new completion.
    do_xfer(1'b1, 8'h08, 32'h1, 4'hF, 1'b0);
    pulse_done();
    check("irq_literal", CW'(irq), CW'(1));
    do_xfer(1'b0, 8'h04, 32'h0, 4'hF, 1'b0);
    check("status_literal", CW'(last_rd), CW'(32'h1));
    do_xfer(1'b1, 8'h04, 32'h1, 4'hF, 1'b1);
    do_xfer(1'b0, 8'h04, 32'h0, 4'hF, 1'b0);
    check("done_set_wins", CW'(last_rd), CW'(32'h1));
    do_xfer(1'b1, 8'h04, 32'h1, 4'hF, 1'b0);
    do_xfer(1'b0, 8'h04, 32'h0, 4'hF, 1'b0);
    check("done_cleared", CW'(last_rd), CW'(32'h0));

    // Error cases.
    do_xfer(1'b0, 8'h06, 32'h0, 4'hF, 1'b0);
    check("err_misaligned", CW'(last_err), CW'(1));
    do_xfer(1'b0, 8'hFC, 32'h0, 4'hF, 1'b0);
    check("err_range", CW'(last_err), CW'(1));
    do_xfer(1'b1, 8'h0C, 32'h1234_5678, 4'hF, 1'b0);
    check("err_version_wr", CW'(last_err), CW'(1));
    do_xfer(1'b0, 8'h0C, 32'h0, 4'hF, 1'b0);
    check("version_literal", CW'(last_rd), CW'(32'h0001_0000));

    // Start pulse, idle and busy core.
    do_xfer(1'b1, 8'h00, 32'h1, 4'hF, 1'b0);
    check("start_literal", CW'(last_start), CW'(1));
    busy_tpu = 1'b1;
    do_xfer(1'b1, 8'h00, 32'h1, 4'hF, 1'b0);
    check("start_busy_none", CW'(last_start), CW'(0));
    check("start_busy_err", CW'(last_err), CW'(1));
    busy_tpu = 1'b0;

    // Byte-lane write over the reset value of register 0.
    do_xfer(1'b1, 8'h10, 32'hFFFF_FFFF, 4'b0010, 1'b0);
    do_xfer(1'b0, 8'h10, 32'h0, 4'hF, 1'b0);
`ifdef CFG_PSTRB_EN
    check("strb_literal", CW'(last_rd), CW'(32'h0000_FFAA));
`else
    check("strb_literal", CW'(last_rd), CW'(32'hFFFF_FFFF));
`endif

    // Reset during SETUP aborts the write; FSM then waits for a fresh SETUP.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'h1234_5678;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESET = 1'b1;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (2) begin
      @(posedge PCLK); #1;
      check("no_access_after_reset", CW'(PREADY), CW'(0));
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    check("cfg_after_abort", cfg_regs, m_flat());
    do_xfer(1'b0, 8'h10, 32'h0, 4'hF, 1'b0);
    check("reg0_after_abort", CW'(last_rd), CW'(32'h0000_00AA));

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) a = 8'(4 * $urandom_range(0, 20));
      else a = 8'($urandom_range(0, 255));
      busy_tpu = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) pulse_done();
      do_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tpu_cfg_regfile.md
TPU_CFG_REGFILE -- requirements
Module: tpu_cfg_regfile

Interface
REQ-001 Parameter ADDR_W, default 8: APB address width in bits.
REQ-002 Parameter DATA_W, default 32: register and APB data width in bits; a multiple of 8.
REQ-003 Parameter NUM_REGS, default 16: number of generic read/write config registers, 1..(2^ADDR_W/4 - 4).
REQ-004 Parameter RST_VALS, default all-zero: NUM_REGS*DATA_W flat reset image; register i occupies bits [i*DATA_W +: DATA_W].
REQ-005 Port list, one per line:
  PCLK  in  1  the block's only clock;
  PRESET  in  1  reset, asynchronous, active-high;
  PADDR  in  ADDR_W  byte address;
  PSEL  in  1  APB select;
  PENABLE  in  1  APB enable;
  PWRITE  in  1  1 = write, 0 = read;
  PWDATA  in  DATA_W  write data;
  PSTRB  in  DATA_W/8  byte strobes, used only under CFG_PSTRB_EN;
  PRDATA  out  DATA_W  read data;
  PREADY  out  1  transfer complete;
  PSLVERR  out  1  error, valid only while PREADY=1;
  done_tpu  in  1  single-cycle completion pulse from the core;
  busy_tpu  in  1  core busy level;
  start_tpu  out  1  single-cycle start pulse;
  irq  out  1  interrupt level;
  cfg_regs  out  NUM_REGS*DATA_W  flat image of the generic registers.

Function
REQ-006 Address map, word-aligned: 0x00 CTRL; 0x04 STATUS; 0x08 IRQ_EN; 0x0C VERSION; 0x10 + 4*i generic register i.
REQ-007 CTRL: writing bit0=1 pulses start_tpu high for exactly the one cycle after the ACCESS cycle; CTRL reads as 0.
REQ-008 STATUS bit0 DONE: sticky; set one cycle after done_tpu=1; cleared by writing 1 (W1C).
REQ-009 STATUS bit1 reads busy_tpu live; all other STATUS bits read 0; writes to bit1 are ignored.
REQ-010 If done_tpu=1 in the same cycle as a W1C of DONE, DONE is set (the set wins).
REQ-011 IRQ_EN bit0 is read/write; irq = DONE & IRQ_EN[0], registered (one cycle after DONE changes).
REQ-012 VERSION is read-only and returns constant 0x0001_0000 zero-extended to DATA_W; a write to it sets PSLVERR.
REQ-013 FSM states:
  IDLE -> SETUP when PSEL & !PENABLE;
  SETUP -> ACCESS when PSEL & PENABLE;
  ACCESS -> IDLE unconditionally.
  Any other input combination returns the FSM to IDLE. This gives exactly one wait state.
REQ-014 PREADY is 1 only in the ACCESS cycle. Register updates and PRDATA are sampled at the end of the SETUP→ACCESS cycle, so PRDATA is valid while PREADY=1.
REQ-015 PSLVERR=1 with PREADY in each of these cases, and no register state changes:
  PADDR[1:0] != 0;
  address beyond 0x10 + 4*(NUM_REGS-1);
  write to VERSION;
  CTRL start write while busy_tpu=1.
REQ-016 On an error read, PRDATA = 0.
REQ-017 PRDATA = 0 in every cycle where PREADY = 0.
REQ-018 cfg_regs reflects a register write from the cycle after ACCESS onward.

Reset
REQ-019 While PRESET is high, asynchronously:
  FSM = IDLE;
  PRDATA = 0; PREADY = 0; PSLVERR = 0;
  start_tpu = 0; irq = 0; DONE = 0; IRQ_EN = 0;
  generic registers = RST_VALS.
REQ-020 A reset asserted mid-transfer aborts the transfer with no partial write. After release, the FSM waits in IDLE for a fresh SETUP phase.

Configuration
REQ-021 Macro CFG_PSTRB_EN defined: writes update only the bytes whose PSTRB bit is 1, for generic registers and IRQ_EN; CTRL and STATUS act only when PSTRB[0]=1.
REQ-022 Macro CFG_PSTRB_EN undefined: the PSTRB port still exists but is ignored, and every write is full-word.

Structure
REQ-023 Shared package tpu_cfg_pkg holds:
  the address offset constants;
  the VERSION constant;
  the FSM state enum (IDLE, SETUP, ACCESS).
REQ-024 One sub-module, tpu_cfg_apb_fsm, decodes the APB phases and produces the wr_en, rd_en and PREADY strobes. Register storage stays in the top module.

Verification
REQ-025 Reset release, then read 0x10 with RST_VALS[31:0]=0x0000_00AA -> PRDATA=0x0000_00AA, PSLVERR=0.
REQ-026 Write 0x14 = 0xDEAD_BEEF, then read 0x14 -> 0xDEAD_BEEF; cfg_regs[63:32]=0xDEAD_BEEF from the cycle after ACCESS.
REQ-027 With IRQ_EN=1, pulse done_tpu -> STATUS reads 0x1 and irq=1. Then write STATUS=0x1 in the same cycle as a second done_tpu pulse -> DONE stays 1.
REQ-028 Read 0x06, read 0xFC, and write 0x0C -> PREADY=1, PSLVERR=1, and all register contents unchanged.
REQ-029 Write CTRL=0x1 with busy_tpu=0 -> start_tpu high for exactly 1 cycle. Repeat with busy_tpu=1 -> no pulse, PSLVERR=1.
REQ-030 With CFG_PSTRB_EN defined, write 0x10 = 0xFFFF_FFFF with PSTRB=4'b0010 over 0x0000_00AA -> read 0x0000_FFAA. Assert PRESET during SETUP -> the register keeps its pre-transfer value (RST_VALS after reset).
